// File: rtl/bist_scheduler.sv
// Round-robin scheduler sharing one BIST pulse controller among N_REQ requesters.
// Issues a start pulse per grant, tracks the session and checks the MISR signature.
module bist_scheduler #(
    parameter int N_REQ     = 4,
    parameter int SIG_W     = 16,
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SIG_W-1:0] golden,
    input  logic [SIG_W-1:0]       sig_in,
    input  logic                   ctl_running,
    input  logic                   ctl_bist_end,
    output logic                   ctl_start,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   pass,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_LEN);
    localparam logic [CNT_W-1:0] TO_CNT    = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_RUN,
        WAIT_END,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic               pick_found;
    logic [CNT_W-1:0]   cnt;
    logic               start_nx;
    logic               abort;
    logic               pass_r;
    logic               to_r;
    logic               sig_match;
    logic [SIG_W-1:0]   gold_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_gold
        assign gold_arr[g] = golden[g*SIG_W +: SIG_W];
    end

    assign sig_match = (sig_in == gold_arr[owner]);

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        pick_oh    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned      j;
            logic [IDX_W-1:0] jj;
            j  = (32'(rr_ptr) + i) % N_REQ;
            jj = IDX_W'(j);
            if (!pick_found && req[jj]) begin
                pick_found = 1'b1;
                pick_idx   = jj;
            end
        end
        pick_oh[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_nx    = 1'b0;
        abort       = 1'b0;
        busy        = (state != IDLE);
        done        = '0;
        pass        = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nx = START;
            end
            START: begin
                start_nx = (cnt < START_CNT);
                if (cnt == START_CNT) state_nx = WAIT_RUN;
            end
            // bist_end may still be high from the previous session here
            WAIT_RUN: begin
                if (cnt == TO_CNT) begin
                    abort    = 1'b1;
                    state_nx = DONE;
                end else if (ctl_running) begin
                    state_nx = WAIT_END;
                end
            end
            WAIT_END: begin
                if (cnt == TO_CNT) begin
                    abort    = 1'b1;
                    state_nx = DONE;
                end else if (!ctl_running && ctl_bist_end) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = DONE;
            end
            DONE: begin
                done        = grant;
                pass        = pass_r;
                timeout_err = to_r;
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_start <= 1'b0;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            pass_r    <= 1'b0;
            to_r      <= 1'b0;
        end else begin
            ctl_start <= start_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|req) begin
                        grant  <= pick_oh;
                        owner  <= pick_idx;
                        pass_r <= 1'b0;
                        to_r   <= 1'b0;
                    end
                end
                START, WAIT_RUN, WAIT_END: begin
                    cnt <= cnt + 1'b1;
                    if (abort) to_r <= 1'b1;
                end
                CHECK: begin
                    pass_r <= sig_match;
                end
                DONE: begin
                    grant  <= '0;
                    cnt    <= '0;
                    rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_scheduler.sv
// Randomized self-checking bench for bist_scheduler: emulates the pulse controller
// and predicts grant order, start timing and results from a round-robin model.
module tb_bist_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SL = 2;
    localparam int TO = 60;

    localparam int M_OK  = 0;
    localparam int M_BAD = 1;
    localparam int M_TO  = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] golden = '0;
    logic [W-1:0]   sig_in = '0;
    logic           ctl_running = 1'b0;
    logic           ctl_bist_end = 1'b0;
    logic           ctl_start;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           pass;
    logic           timeout_err;
    logic           busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned mptr     = 0;

    bist_scheduler #(
        .N_REQ    (N),
        .SIG_W    (W),
        .START_LEN(SL),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .golden      (golden),
        .sig_in      (sig_in),
        .ctl_running (ctl_running),
        .ctl_bist_end(ctl_bist_end),
        .ctl_start   (ctl_start),
        .grant       (grant),
        .done        (done),
        .pass        (pass),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned p);
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // One full session: controller emulation plus timing/result checks.
    task automatic session(input int mode, input bit hold, input bit drop,
                           input int unsigned run_delay, input int unsigned run_len);
        int unsigned  exp_idx;
        int unsigned  t0;
        int unsigned  lat;
        int unsigned  hi;
        logic [N-1:0] exp_oh;
        logic [W-1:0] gold_s;
        bit           seen;
        bit           early;

        exp_idx = rr_pick(req, mptr);
        exp_oh  = N'(1) << exp_idx;
        gold_s  = golden[exp_idx*W +: W];
        seen    = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) seen = 1'b1;
        end
        check("grant_seen", 32'(seen), 1);
        if (!seen) return;
        check("grant", 32'(grant), 32'(exp_oh));
        check("start_lat", 32'(ctl_start), 0);
        check("busy", 32'(busy), 1);
        t0 = cyc;
        if (drop) req[exp_idx] = 1'b0;

        hi = 0;
        @(negedge clk);
        while (ctl_start && hi < 10) begin
            hi++;
            @(negedge clk);
        end
        check("start_len", hi, SL);

        if (mode == M_TO) begin
            seen = 1'b0;
            for (int i = 0; i < TO + 20 && !seen; i++) begin
                @(negedge clk);
                if (done != '0) seen = 1'b1;
            end
            check("to_done_seen", 32'(seen), 1);
            check("to_lat", cyc - t0, TO + 1);
        end else begin
            early = 1'b0;
            for (int unsigned i = 0; i < run_delay; i++) begin
                @(negedge clk);
                if (done != '0) early = 1'b1;
            end
            ctl_running  = 1'b1;
            ctl_bist_end = 1'b0;
            for (int unsigned i = 0; i < run_len; i++) begin
                @(negedge clk);
                if (done != '0) early = 1'b1;
            end
            ctl_running  = 1'b0;
            ctl_bist_end = 1'b1;
            sig_in = (mode == M_BAD) ? (gold_s ^ W'($urandom_range(1, 16'hffff))) : gold_s;
            check("early_done", 32'(early), 0);
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 10) begin
                @(negedge clk);
                lat++;
                if (done != '0) seen = 1'b1;
            end
            check("end_lat", lat, 2);
        end
        if (!seen) return;
        check("done", 32'(done), 32'(exp_oh));
        check("grant_hold", 32'(grant), 32'(exp_oh));
        check("pass", 32'(pass), 32'(mode == M_OK));
        check("timeout_err", 32'(timeout_err), 32'(mode == M_TO));
        mptr = (exp_idx + 1) % N;
        if (!hold) req[exp_idx] = 1'b0;
        @(negedge clk);
        check("done_1cyc", 32'(done), 0);
        check("grant_clr", 32'(grant), 0);
        check("pass_clr", 32'(pass), 0);
    endtask

    initial begin
        int  mode;
        bit  drop;
        bit  seen;
        bit  stray;

        golden = {$urandom, $urandom};
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl_start", 32'(ctl_start), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // single requester, good signature
        mptr = 0;
        req  = 4'b0001;
        session(M_OK, 1'b0, 1'b0, 3, 4);

        // all requesting from a fresh pointer: 0,1,2,3,0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mptr  = 0;
        @(negedge clk);
        golden = {$urandom, $urandom};
        req    = 4'b1111;
        repeat (5) session(M_OK, 1'b1, 1'b0, $urandom_range(0, 4), $urandom_range(1, 5));
        req = '0;

        // wrong signature on requester 2
        req = 4'b0100;
        session(M_BAD, 1'b0, 1'b0, 2, 3);

        // controller never runs, then normal service resumes
        req = 4'b0010;
        session(M_TO, 1'b0, 1'b0, 0, 0);
        req = 4'b1000;
        session(M_OK, 1'b0, 1'b0, 2, 2);

        // randomized contention, signatures and mid-session drops
        repeat (12) begin
            if (req == '0) req = N'($urandom_range(1, 15));
            else req = req | N'($urandom);
            golden = {$urandom, $urandom};
            mode   = ($urandom_range(0, 3) == 0) ? M_BAD : M_OK;
            drop   = ($urandom_range(0, 3) == 0);
            session(mode, 1'b0, drop, $urandom_range(2, 5), $urandom_range(1, 4));
        end
        req = '0;

        // reset pulled during WAIT_END
        @(negedge clk);
        req  = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) seen = 1'b1;
        end
        check("mr_grant_seen", 32'(seen), 1);
        repeat (3) @(negedge clk);
        ctl_running  = 1'b1;
        ctl_bist_end = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("mr_ctl_start", 32'(ctl_start), 0);
        check("mr_grant", 32'(grant), 0);
        check("mr_done", 32'(done), 0);
        check("mr_pass", 32'(pass), 0);
        check("mr_timeout", 32'(timeout_err), 0);
        check("mr_busy_low", 32'(busy), 0);
        @(negedge clk);
        ctl_running = 1'b0;
        req   = '0;
        reset = 1'b1;
        mptr  = 0;
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0 || busy) stray = 1'b1;
        end
        check("mr_no_done", 32'(stray), 0);

        req = 4'b0010;
        session(M_OK, 1'b0, 1'b0, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
